// File: rtl/serial_full_adder_seq_pkg.sv
// Shared types and sizing helpers for the bit-serial adder slice.
package serial_add_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

  // Counter width that stays at least one bit for the smallest legal WIDTH.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_full_adder_seq_if.sv
// Operand/result bundle between a requester and the serial adder.
interface serial_full_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             carry_out;

  modport master (
    output en, start, A, B, carry_in,
    input  busy, done, SUM, carry_out
  );

  modport slave (
    input  en, start, A, B, carry_in,
    output busy, done, SUM, carry_out
  );
endinterface

// File: rtl/serial_full_adder_seq_fa_cell.sv
// Single-bit full adder: the only arithmetic in the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_full_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB first.
// Results are published only on the completion edge together with a done pulse.
module serial_full_adder_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_full_adder_seq_if.slave bus
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e             state_r, state_n;
  logic [WIDTH-1:0]   a_r, a_n;
  logic [WIDTH-1:0]   b_r, b_n;
  logic [WIDTH-1:0]   psum_r, psum_n;
  logic [WIDTH-1:0]   sum_r, sum_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic               c_r, c_n;
  logic               cout_r, cout_n;
  logic               done_r, done_n;
  logic               busy_r, busy_n;
  logic               fa_s_s;
  logic               fa_cout_s;
  logic [WIDTH-1:0]   psum_shift_s;

  fa_cell u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (c_r),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign psum_shift_s = (psum_r >> 1) | {fa_s_s, {(WIDTH-1){1'b0}}};

  // Next-state and datapath update; en=0 leaves everything but done untouched.
  always_comb begin
    state_n = state_r;
    a_n     = a_r;
    b_n     = b_r;
    psum_n  = psum_r;
    sum_n   = sum_r;
    cnt_n   = cnt_r;
    c_n     = c_r;
    cout_n  = cout_r;
    done_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.en && bus.start) begin
          state_n = RUN;
          a_n     = bus.A;
          b_n     = bus.B;
          c_n     = bus.carry_in;
          cnt_n   = {CNT_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (bus.en) begin
          a_n    = a_r >> 1;
          b_n    = b_r >> 1;
          c_n    = fa_cout_s;
          psum_n = psum_shift_s;
          if (cnt_r == LAST) begin
            state_n = IDLE;
            sum_n   = psum_shift_s;
            cout_n  = fa_cout_s;
            done_n  = 1'b1;
            cnt_n   = {CNT_W{1'b0}};
          end else begin
            state_n = RUN;
            cnt_n   = cnt_r + CNT_W'(1);
          end
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == RUN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      psum_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      c_r     <= 1'b0;
      cout_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      a_r     <= a_n;
      b_r     <= b_n;
      psum_r  <= psum_n;
      sum_r   <= sum_n;
      cnt_r   <= cnt_n;
      c_r     <= c_n;
      cout_r  <= cout_n;
      done_r  <= done_n;
      busy_r  <= busy_n;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.SUM       = sum_r;
  assign bus.carry_out = cout_r;

endmodule

// File: tb/tb_serial_full_adder_seq.sv
// Self-checking bench: arithmetic reference model checked every cycle, plus directed cases.
module tb_serial_full_adder_seq;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  serial_full_adder_seq_if #(.WIDTH(W)) bus ();

  serial_full_adder_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is a number; it completes after W enabled edges.
  logic         m_busy, m_done, m_cout;
  logic [W-1:0] m_sum;
  logic [W:0]   m_res;
  int           m_left;
  int           m_acc = 0;
  int           m_abort = 0;
  int           dut_done_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_busy === 1'b1) m_abort++;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (bus.en) begin
          m_left--;
          if (m_left == 0) begin
            {m_cout, m_sum} = m_res;
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end else if (bus.en && bus.start) begin
        m_res  = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, bus.carry_in};
        m_left = W;
        m_busy = 1'b1;
        m_acc++;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
      check("done", {31'd0, bus.done}, {31'd0, m_done});
      check("sum", {24'd0, bus.SUM}, {24'd0, m_sum});
      check("cout", {31'd0, bus.carry_out}, {31'd0, m_cout});
      if (bus.done) dut_done_cnt++;
    end
  end

  // mode 0 plain, 1 stall en for 3 cycles, 2 re-assert start mid-run
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic now, input int mode, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input int exp_lat, input int exp_busy,
                       input string tag);
    int cyc;
    int busy_cnt;
    logic [W-1:0] held;
    if (!now) @(negedge clk);
    bus.A = a; bus.B = b; bus.carry_in = cin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    held = bus.SUM;
    cyc = 1;
    busy_cnt = 0;
    while (!bus.done && cyc < 100) begin
      if (bus.busy) busy_cnt++;
      if (mode == 1 && cyc == 3) bus.en = 1'b0;
      if (mode == 1 && cyc == 6) begin
        bus.en = 1'b1;
        check({tag, "_sum_held"}, {24'd0, bus.SUM}, {24'd0, held});
      end
      if (mode == 2 && cyc == 4) begin bus.A = '0; bus.B = '0; bus.start = 1'b1; end
      if (mode == 2 && cyc == 5) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_sum"}, {24'd0, bus.SUM}, {24'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, bus.carry_out}, {31'd0, exp_cout});
    if (exp_busy > 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.carry_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_sum", {24'd0, bus.SUM}, 32'd0);
    check("rst_cout", {31'd0, bus.carry_out}, 32'd0);

    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, 8'h7F, 1'b0, W + 1, W, "t35_4a");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, W + 1, 0, "tff_01");
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b1, W + 1, 0, "tff_ff_c");
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1, 8'h10, 1'b0, W + 4, 0, "tstall");
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 2, 8'h46, 1'b0, W + 1, 0, "tignore");
    do_op(8'h01, 8'h01, 1'b0, 1'b1, 0, 8'h02, 1'b0, W + 1, 0, "tb2b");

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    bus.A = 8'hAA; bus.B = 8'h55; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_sum", {24'd0, bus.SUM}, 32'd0);
    check("abort_cout", {31'd0, bus.carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    do_op(8'hAA, 8'h55, 1'b0, 1'b0, 0, 8'hFF, 1'b0, W + 1, 0, "taa_55");

    // Random operands, start and enable gaps; the model checks every cycle.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.start    = $urandom_range(0, 1) != 0;
      bus.A        = W'($urandom);
      bus.B        = W'($urandom);
      bus.carry_in = $urandom_range(0, 1) != 0;
    end
    @(negedge clk);
    bus.en = 1'b1; bus.start = 1'b0;
    repeat (3 * W) @(negedge clk);
    check("done_per_start", dut_done_cnt, m_acc - m_abort);
    check("ops_accepted", {31'd0, m_acc > 500}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
